// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, registered EX/MEM forwarding
// selects, one-bubble load-use interlock, flush, hold and saturating stall count.
module id_ex_stage #(
  parameter int N   = 24,
  parameter int RA  = 4,
  parameter int CW  = 4,
  parameter int SCW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           id_valid,
  input  logic [N-1:0]   id_rd1,
  input  logic [N-1:0]   id_rd2,
  input  logic [N-1:0]   id_pc,
  input  logic [N-1:0]   id_imm,
  input  logic [RA-1:0]  id_rs1,
  input  logic [RA-1:0]  id_rs2,
  input  logic [RA-1:0]  id_rd,
  input  logic [CW-1:0]  id_aluControl,
  input  logic           id_immSrc,
  input  logic           id_branchFlag,
  input  logic           id_regWrite,
  input  logic           id_memRead,
  input  logic           flush,
  input  logic           hold,
  input  logic           wb_regWrite,
  input  logic [RA-1:0]  wb_rd,
  input  logic [N-1:0]   wb_result,
  output logic           ex_valid,
  output logic           ex_immSrc,
  output logic           ex_branchFlag,
  output logic           ex_regWrite,
  output logic           ex_memRead,
  output logic [N-1:0]   ex_rd1,
  output logic [N-1:0]   ex_rd2,
  output logic [N-1:0]   ex_pc,
  output logic [N-1:0]   ex_imm,
  output logic [CW-1:0]  ex_aluControl,
  output logic [RA-1:0]  ex_rd,
  output logic           Fa,
  output logic           Fb,
  output logic           id_stall,
  output logic [SCW-1:0] stall_count,
  output logic           o_dbg_state
);

  typedef enum logic {
    S_RUN      = 1'b0,
    S_LU_STALL = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic         w_lu;
  logic         w_do_bubble;
  logic         w_do_normal;
  logic         w_cnt_inc;
  logic         w_stall;
  logic         w_fa_nxt;
  logic         w_fb_nxt;
  logic         w_wb_hit1;
  logic         w_wb_hit2;
  logic [N-1:0] w_rd1_nxt;
  logic [N-1:0] w_rd2_nxt;

  // Only a load sitting in EX can create a hazard; ALU results are forwarded instead.
  assign w_lu = ex_valid & ex_memRead & (ex_rd != '0) & id_valid &
                ((id_rs1 == ex_rd) | (id_rs2 == ex_rd));

  assign w_wb_hit1 = wb_regWrite & (wb_rd != '0) & (wb_rd == id_rs1);
  assign w_wb_hit2 = wb_regWrite & (wb_rd != '0) & (wb_rd == id_rs2);
  assign w_rd1_nxt = w_wb_hit1 ? wb_result : id_rd1;
  assign w_rd2_nxt = w_wb_hit2 ? wb_result : id_rd2;

  // Selects are derived from the instruction being replaced in EX (it moves to MEM).
  assign w_fa_nxt = ex_valid & ex_regWrite & ~ex_memRead & (ex_rd != '0) & (ex_rd == id_rs1);
  assign w_fb_nxt = ex_valid & ex_regWrite & ~ex_memRead & (ex_rd != '0) & (ex_rd == id_rs2);

  always_comb begin
    w_state_nxt = r_state;
    w_do_bubble = 1'b0;
    w_do_normal = 1'b0;
    w_cnt_inc   = 1'b0;
    w_stall     = 1'b0;
    if (hold) begin
      w_stall = 1'b1;
    end else if (flush) begin
      w_do_bubble = 1'b1;
      w_state_nxt = S_RUN;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_lu) begin
            w_do_bubble = 1'b1;
            w_cnt_inc   = 1'b1;
            w_stall     = 1'b1;
            w_state_nxt = S_LU_STALL;
          end else begin
            w_do_normal = 1'b1;
          end
        end
        S_LU_STALL: begin
          w_do_normal = 1'b1;
          w_state_nxt = S_RUN;
        end
        default: begin
          w_state_nxt = S_RUN;
        end
      endcase
    end
  end

  assign id_stall    = rst & w_stall;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_RUN;
      ex_valid      <= 1'b0;
      ex_immSrc     <= 1'b0;
      ex_branchFlag <= 1'b0;
      ex_regWrite   <= 1'b0;
      ex_memRead    <= 1'b0;
      ex_rd1        <= '0;
      ex_rd2        <= '0;
      ex_pc         <= '0;
      ex_imm        <= '0;
      ex_aluControl <= '0;
      ex_rd         <= '0;
      Fa            <= 1'b0;
      Fb            <= 1'b0;
      stall_count   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_do_bubble) begin
        ex_valid      <= 1'b0;
        ex_branchFlag <= 1'b0;
        ex_regWrite   <= 1'b0;
        ex_memRead    <= 1'b0;
        Fa            <= 1'b0;
        Fb            <= 1'b0;
      end
      if (w_do_normal) begin
        ex_valid      <= id_valid;
        ex_immSrc     <= id_immSrc;
        ex_branchFlag <= id_branchFlag;
        ex_regWrite   <= id_regWrite & id_valid;
        ex_memRead    <= id_memRead & id_valid;
        ex_rd1        <= w_rd1_nxt;
        ex_rd2        <= w_rd2_nxt;
        ex_pc         <= id_pc;
        ex_imm        <= id_imm;
        ex_aluControl <= id_aluControl;
        ex_rd         <= id_rd;
        Fa            <= w_fa_nxt;
        Fb            <= w_fb_nxt;
      end
      if (w_cnt_inc && (stall_count != {SCW{1'b1}})) begin
        stall_count <= stall_count + {{(SCW-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a default-width instance plus a 2-bit stall
// counter instance sharing the same stimulus.
module tb_id_ex_stage;

  localparam int N  = 24;
  localparam int RA = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [N-1:0]  id_rd1, id_rd2, id_pc, id_imm;
  logic [RA-1:0] id_rs1, id_rs2, id_rd;
  logic [CW-1:0] id_aluControl;
  logic          id_immSrc, id_branchFlag, id_regWrite, id_memRead;
  logic          flush, hold;
  logic          wb_regWrite;
  logic [RA-1:0] wb_rd;
  logic [N-1:0]  wb_result;

  logic          ex_valid, ex_immSrc, ex_branchFlag, ex_regWrite, ex_memRead;
  logic [N-1:0]  ex_rd1, ex_rd2, ex_pc, ex_imm;
  logic [CW-1:0] ex_aluControl;
  logic [RA-1:0] ex_rd;
  logic          Fa, Fb, id_stall, dbg_state;
  logic [15:0]   stall_count;

  logic          s_valid, s_immSrc, s_branchFlag, s_regWrite, s_memRead;
  logic [N-1:0]  s_rd1, s_rd2, s_pc, s_imm;
  logic [CW-1:0] s_aluControl;
  logic [RA-1:0] s_rd;
  logic          s_Fa, s_Fb, s_id_stall, s_dbg_state;
  logic [1:0]    s_stall_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.N(N), .RA(RA), .CW(CW), .SCW(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_pc(id_pc), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_aluControl(id_aluControl), .id_immSrc(id_immSrc), .id_branchFlag(id_branchFlag),
    .id_regWrite(id_regWrite), .id_memRead(id_memRead), .flush(flush), .hold(hold),
    .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_immSrc(ex_immSrc), .ex_branchFlag(ex_branchFlag),
    .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_aluControl(ex_aluControl), .ex_rd(ex_rd),
    .Fa(Fa), .Fb(Fb), .id_stall(id_stall), .stall_count(stall_count), .o_dbg_state(dbg_state)
  );

  id_ex_stage #(.N(N), .RA(RA), .CW(CW), .SCW(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_pc(id_pc), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_aluControl(id_aluControl), .id_immSrc(id_immSrc), .id_branchFlag(id_branchFlag),
    .id_regWrite(id_regWrite), .id_memRead(id_memRead), .flush(flush), .hold(hold),
    .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .ex_valid(s_valid), .ex_immSrc(s_immSrc), .ex_branchFlag(s_branchFlag),
    .ex_regWrite(s_regWrite), .ex_memRead(s_memRead), .ex_rd1(s_rd1), .ex_rd2(s_rd2),
    .ex_pc(s_pc), .ex_imm(s_imm), .ex_aluControl(s_aluControl), .ex_rd(s_rd),
    .Fa(s_Fa), .Fb(s_Fb), .id_stall(s_id_stall), .stall_count(s_stall_count),
    .o_dbg_state(s_dbg_state)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input logic v, input logic [RA-1:0] rs1, input logic [RA-1:0] rs2,
                           input logic [RA-1:0] rd, input logic rw, input logic mr,
                           input logic [N-1:0] d1, input logic [N-1:0] d2,
                           input logic [N-1:0] pc, input logic [CW-1:0] alu);
    id_valid      = v;
    id_rs1        = rs1;
    id_rs2        = rs2;
    id_rd         = rd;
    id_regWrite   = rw;
    id_memRead    = mr;
    id_rd1        = d1;
    id_rd2        = d2;
    id_pc         = pc;
    id_imm        = 24'h000010;
    id_aluControl = alu;
  endtask

  initial begin
    // Reset with random inputs, including hold/flush
    rst           = 1'b0;
    id_valid      = 1'($urandom_range(0, 1));
    id_rd1        = N'($urandom);
    id_rd2        = N'($urandom);
    id_pc         = N'($urandom);
    id_imm        = N'($urandom);
    id_rs1        = RA'($urandom);
    id_rs2        = RA'($urandom);
    id_rd         = RA'($urandom);
    id_aluControl = CW'($urandom);
    id_immSrc     = 1'($urandom_range(0, 1));
    id_branchFlag = 1'($urandom_range(0, 1));
    id_regWrite   = 1'($urandom_range(0, 1));
    id_memRead    = 1'($urandom_range(0, 1));
    flush         = 1'($urandom_range(0, 1));
    hold          = 1'($urandom_range(0, 1));
    wb_regWrite   = 1'($urandom_range(0, 1));
    wb_rd         = RA'($urandom);
    wb_result     = N'($urandom);
    tick;
    tick;
    chk("rst_ex_valid", 32'(ex_valid), 32'h0);
    chk("rst_ex_regWrite", 32'(ex_regWrite), 32'h0);
    chk("rst_ex_rd1", 32'(ex_rd1), 32'h0);
    chk("rst_ex_pc", 32'(ex_pc), 32'h0);
    chk("rst_ex_aluControl", 32'(ex_aluControl), 32'h0);
    chk("rst_Fa_Fb", {30'h0, Fa, Fb}, 32'h0);
    chk("rst_stall_count", 32'(stall_count), 32'h0);
    chk("rst_id_stall", 32'(id_stall), 32'h0);

    // First capture after reset release
    flush = 1'b0; hold = 1'b0; wb_regWrite = 1'b0; wb_rd = '0; wb_result = '0;
    rst = 1'b1;
    set_instr(1'b1, 4'd1, 4'd2, 4'd7, 1'b0, 1'b0, 24'd2, 24'd2, 24'h40, 4'd1);
    id_branchFlag = 1'b1;
    id_immSrc     = 1'b1;
    tick;
    chk("cap_ex_valid", 32'(ex_valid), 32'h1);
    chk("cap_ex_rd1", 32'(ex_rd1), 32'h2);
    chk("cap_ex_rd2", 32'(ex_rd2), 32'h2);
    chk("cap_ex_aluControl", 32'(ex_aluControl), 32'h1);
    chk("cap_ex_branchFlag", 32'(ex_branchFlag), 32'h1);
    chk("cap_ex_pc", 32'(ex_pc), 32'h40);
    chk("cap_ex_rd", 32'(ex_rd), 32'h7);
    id_branchFlag = 1'b0;
    id_immSrc     = 1'b0;

    // ALU forwarding: A writes r3, B reads r3/r5
    set_instr(1'b1, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 24'h1, 24'h1, 24'h44, 4'd2);
    tick;
    chk("fwdA_ex_regWrite", 32'(ex_regWrite), 32'h1);
    set_instr(1'b1, 4'd3, 4'd5, 4'd6, 1'b0, 1'b0, 24'hA, 24'hB, 24'h48, 4'd2);
    tick;
    chk("fwd_Fa", 32'(Fa), 32'h1);
    chk("fwd_Fb", 32'(Fb), 32'h0);
    // Destination r0 never forwards
    set_instr(1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 24'h1, 24'h1, 24'h4C, 4'd2);
    tick;
    set_instr(1'b1, 4'd0, 4'd5, 4'd6, 1'b0, 1'b0, 24'hA, 24'hB, 24'h50, 4'd2);
    tick;
    chk("fwd_r0_Fa", 32'(Fa), 32'h0);
    // Same source on both operands
    set_instr(1'b1, 4'd0, 4'd0, 4'd9, 1'b1, 1'b0, 24'h1, 24'h1, 24'h54, 4'd2);
    tick;
    set_instr(1'b1, 4'd9, 4'd9, 4'd6, 1'b0, 1'b0, 24'hA, 24'hB, 24'h58, 4'd2);
    tick;
    chk("fwd_both", {30'h0, Fa, Fb}, 32'h3);

    // Load-use: load r4, then consumer of r4 on rs2
    set_instr(1'b1, 4'd0, 4'd0, 4'd4, 1'b1, 1'b1, 24'h1, 24'h1, 24'h5C, 4'd0);
    tick;
    set_instr(1'b1, 4'd1, 4'd4, 4'd8, 1'b1, 1'b0, 24'h11, 24'h22, 24'h200, 4'd2);
    #1;
    chk("lu_id_stall_on", 32'(id_stall), 32'h1);
    tick;
    chk("lu_bubble_valid", 32'(ex_valid), 32'h0);
    chk("lu_bubble_regWrite", 32'(ex_regWrite), 32'h0);
    chk("lu_state", 32'(dbg_state), 32'h1);
    chk("lu_count", 32'(stall_count), 32'h1);
    wb_regWrite = 1'b1; wb_rd = 4'd4; wb_result = 24'h00ABCD;
    #1;
    chk("lu_id_stall_off", 32'(id_stall), 32'h0);
    tick;
    chk("lu_issue_valid", 32'(ex_valid), 32'h1);
    chk("lu_wb_bypass_rd2", 32'(ex_rd2), 32'h00ABCD);
    chk("lu_rd1_nobypass", 32'(ex_rd1), 32'h11);
    chk("lu_issue_Fb", 32'(Fb), 32'h0);
    chk("lu_issue_pc", 32'(ex_pc), 32'h200);
    chk("lu_run_state", 32'(dbg_state), 32'h0);
    chk("lu_count_after", 32'(stall_count), 32'h1);
    wb_regWrite = 1'b0; wb_rd = '0; wb_result = '0;

    // Flush while load-use is present
    set_instr(1'b1, 4'd0, 4'd0, 4'd5, 1'b1, 1'b1, 24'h1, 24'h1, 24'h204, 4'd0);
    tick;
    set_instr(1'b1, 4'd5, 4'd0, 4'd10, 1'b1, 1'b0, 24'h1, 24'h1, 24'h208, 4'd2);
    flush = 1'b1;
    #1;
    chk("flush_id_stall", 32'(id_stall), 32'h0);
    tick;
    flush = 1'b0;
    chk("flush_ex_valid", 32'(ex_valid), 32'h0);
    chk("flush_ex_memRead", 32'(ex_memRead), 32'h0);
    chk("flush_count", 32'(stall_count), 32'h1);
    chk("flush_state", 32'(dbg_state), 32'h0);

    // Hold across LU_STALL
    set_instr(1'b1, 4'd0, 4'd0, 4'd6, 1'b1, 1'b1, 24'h66, 24'h66, 24'h20C, 4'd0);
    tick;
    set_instr(1'b1, 4'd6, 4'd0, 4'd10, 1'b1, 1'b0, 24'h33, 24'h44, 24'h100, 4'd3);
    #1;
    chk("hold_pre_stall", 32'(id_stall), 32'h1);
    tick;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_lu_id_stall", 32'(id_stall), 32'h1);
      tick;
      chk("hold_lu_valid", 32'(ex_valid), 32'h0);
      chk("hold_lu_state", 32'(dbg_state), 32'h1);
      chk("hold_lu_count", 32'(stall_count), 32'h2);
    end
    hold = 1'b0;
    #1;
    chk("hold_release_stall", 32'(id_stall), 32'h0);
    tick;
    chk("hold_D_valid", 32'(ex_valid), 32'h1);
    chk("hold_D_rd1", 32'(ex_rd1), 32'h33);
    chk("hold_D_pc", 32'(ex_pc), 32'h100);
    chk("hold_D_state", 32'(dbg_state), 32'h0);

    // Hold in RUN with a valid instruction in EX
    set_instr(1'b1, 4'd10, 4'd0, 4'd11, 1'b0, 1'b0, 24'h77, 24'h88, 24'h104, 4'd4);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_run_id_stall", 32'(id_stall), 32'h1);
      tick;
      chk("hold_run_pc", 32'(ex_pc), 32'h100);
      chk("hold_run_Fa", 32'(Fa), 32'h0);
    end
    hold = 1'b0;
    tick;
    chk("hold_E_pc", 32'(ex_pc), 32'h104);
    chk("hold_E_Fa", 32'(Fa), 32'h1);
    set_instr(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 24'h0, 24'h0, 24'h0, 4'd0);
    tick;
    chk("hold_no_dup", 32'(ex_valid), 32'h0);

    // Saturation: five more load-use pairs
    for (int i = 0; i < 5; i++) begin
      set_instr(1'b1, 4'd0, 4'd0, 4'd12, 1'b1, 1'b1, 24'h1, 24'h1, 24'h300, 4'd0);
      tick;
      set_instr(1'b1, 4'd12, 4'd0, 4'd13, 1'b0, 1'b0, 24'h1, 24'h1, 24'h304, 4'd1);
      tick;
      tick;
      if (i == 0) begin
        chk("sat_main_3", 32'(stall_count), 32'h3);
        chk("sat_small_3", 32'(s_stall_count), 32'h3);
      end
    end
    chk("sat_main_7", 32'(stall_count), 32'h7);
    chk("sat_small_stuck", 32'(s_stall_count), 32'h3);

    // Asynchronous reset in the middle of a stall
    set_instr(1'b1, 4'd0, 4'd0, 4'd14, 1'b1, 1'b1, 24'h55, 24'h56, 24'h300, 4'd5);
    tick;
    set_instr(1'b1, 4'd14, 4'd0, 4'd15, 1'b0, 1'b0, 24'h1, 24'h1, 24'h308, 4'd1);
    tick;
    chk("arst_pre_state", 32'(dbg_state), 32'h1);
    chk("arst_pre_count", 32'(stall_count), 32'h8);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ex_rd1", 32'(ex_rd1), 32'h0);
    chk("arst_ex_pc", 32'(ex_pc), 32'h0);
    chk("arst_count", 32'(stall_count), 32'h0);
    chk("arst_small_count", 32'(s_stall_count), 32'h0);
    chk("arst_state", 32'(dbg_state), 32'h0);
    chk("arst_id_stall", 32'(id_stall), 32'h0);
    tick;
    rst = 1'b1;
    tick;
    chk("refetch_valid", 32'(ex_valid), 32'h1);
    chk("refetch_rd", 32'(ex_rd), 32'hF);
    chk("refetch_state", 32'(dbg_state), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
